seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/edge_sync.sv | 31 +++
 rtl/seg7_scan.sv | 124 ++++++++++++
 tb/tb_seg7_scan.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
//   SEG_BLANK  : active-low segment pattern with every segment dark.
//   HEX_SEG    : 16-entry hex-to-segment table, bit order {g,f,e,d,c,b,a}, active-low.
//   hex_to_seg : table lookup helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed array: the left-most entry is index 15 (F), the right-most is index 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronises a slow asynchronous clock-like input and produces a one-cycle
// rising-edge strobe.
//   clk_i   : sampling clock
//   rst_ni  : asynchronous active-low reset (clears sync chain and history)
//   async_i : asynchronous input level
//   edge_o  : high for one clk_i cycle after a synchronised rising edge
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment driver. Each synchronised scan_clk rising edge
// advances to the next digit; inputs are latched into shadow registers only
// when the scan wraps to digit 0, so a whole frame shows one consistent copy.
//   clk100MHz  : system clock
//   rst_n      : asynchronous active-low reset
//   scan_clk   : slow digit-advance clock (asynchronous)
//   step_clk   : slow step clock (asynchronous), one step_pulse per rising edge
//   data       : hex nibbles, digit i = data[4i+3:4i]
//   dp_in      : per-digit decimal point request, 1 = lit
//   blank      : per-digit blank, 1 = dark
//   an         : active-low digit anodes
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   step_pulse : registered single-cycle pulse
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk100MHz,
  input  logic                    rst_n,
  input  logic                    scan_clk,
  input  logic                    step_clk,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    step_pulse
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic scan_edge;
  logic step_edge;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scan_sync (
    .clk_i   (clk100MHz),
    .rst_ni  (rst_n),
    .async_i (scan_clk),
    .edge_o  (scan_edge)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk_i   (clk100MHz),
    .rst_ni  (rst_n),
    .async_i (step_clk),
    .edge_o  (step_edge)
  );

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    step_q;
  logic [3:0]              nib;

  always_comb begin
    idx_d      = idx_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    an_d       = an_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    nib        = 4'h0;
    if (scan_edge) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      // Latch a fresh frame on entry to digit 0; digit 0 itself already
      // displays the newly captured values.
      if (idx_d == '0) begin
        sh_data_d  = data;
        sh_dp_d    = dp_in;
        sh_blank_d = blank;
      end
      nib = sh_data_d[{idx_d, 2'b00} +: 4];
      if (sh_blank_d[idx_d]) begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          an_d[i] = (idx_d != IDX_W'(i));
        end
        seg_d = hex_to_seg(nib);
        dp_d  = ~sh_dp_d[idx_d];
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= LAST_IDX;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      step_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      step_q     <= step_edge;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic        scan4_clk;
  logic        step_clk;
  logic [31:0] data;
  logic [7:0]  dp_in;
  logic [7:0]  blank;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        step_pulse;
  logic [3:0]  an4;
  logic [6:0]  seg4;
  logic        dp4;
  logic        step_pulse4;

  int total = 0;
  int bad   = 0;
  int step_hi   = 0;
  int step_rise = 0;
  logic step_prev = 1'b0;

  always #5 clk = ~clk;

  seg7_scan #(.NUM_DIGITS(8), .SYNC_STAGES(2)) dut (
    .clk100MHz  (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .step_clk   (step_clk),
    .data       (data),
    .dp_in      (dp_in),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .step_pulse (step_pulse)
  );

  seg7_scan #(.NUM_DIGITS(4), .SYNC_STAGES(2)) dut4 (
    .clk100MHz  (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan4_clk),
    .step_clk   (step_clk),
    .data       (data[15:0]),
    .dp_in      (dp_in[3:0]),
    .blank      (blank[3:0]),
    .an         (an4),
    .seg        (seg4),
    .dp         (dp4),
    .step_pulse (step_pulse4)
  );

  always @(negedge clk) begin
    if (step_pulse) step_hi++;
    if (step_pulse && !step_prev) step_rise++;
    step_prev = step_pulse;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic scan_edge();
    scan_clk = 1'b1;
    repeat (4) @(negedge clk);
    scan_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic scan4_edge();
    scan4_clk = 1'b1;
    repeat (4) @(negedge clk);
    scan4_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Hand-computed anode and segment codes for data = 32'h0123_89AF.
  logic [7:0] exp_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] exp_seg [8] = '{7'h0E, 7'h08, 7'h10, 7'h00, 7'h30, 7'h24, 7'h79, 7'h40};
  int half [5] = '{2, 3, 10, 50, 500};

  initial begin
    int hi0, rise0, k;
    rst_n = 1'b0; scan_clk = 1'b0; scan4_clk = 1'b0; step_clk = 1'b0;
    data = 32'h0123_89AF; dp_in = 8'h00; blank = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_an", an, 8'hFF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_step", step_pulse, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First edge latency: update lands on the 3rd rising edge.
    scan_clk = 1'b1;
    @(negedge clk);
    check("lat_e1_an", an, 8'hFF);
    @(negedge clk);
    check("lat_e2_an", an, 8'hFF);
    @(negedge clk);
    check("lat_e3_an", an, 8'hFE);
    check("lat_e3_seg", seg, 7'h0E);
    @(negedge clk);
    scan_clk = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 1; i < 8; i++) begin
      scan_edge();
      check($sformatf("scan_an%0d", i), an, exp_an[i]);
      check($sformatf("scan_seg%0d", i), seg, exp_seg[i]);
      check($sformatf("scan_dp%0d", i), dp, 1'b1);
    end

    // Mid-frame data change must wait for the next wrap.
    for (int i = 0; i < 4; i++) scan_edge();
    check("mid_idx3_an", an, 8'hF7);
    data = 32'hFFFF_FFFF;
    for (int i = 4; i < 8; i++) begin
      scan_edge();
      check($sformatf("mid_old_seg%0d", i), seg, exp_seg[i]);
    end
    scan_edge();
    check("wrap_d0_seg", seg, 7'h0E);
    scan_edge();
    check("wrap_d1_seg", seg, 7'h0E);

    // Blank slot 2, decimal point on digit 0 (takes effect at next wrap).
    data = 32'h0123_89AF; blank = 8'h04; dp_in = 8'h01;
    for (int i = 2; i < 8; i++) scan_edge();
    check("pre_blank_seg7", seg, 7'h0E);
    scan_edge();
    check("dp_d0_an", an, 8'hFE);
    check("dp_d0_dp", dp, 1'b0);
    scan_edge();
    check("dp_d1_dp", dp, 1'b1);
    scan_edge();
    check("blank_d2_an", an, 8'hFF);
    check("blank_d2_seg", seg, 7'h7F);
    check("blank_d2_dp", dp, 1'b1);
    scan_edge();
    check("blank_d3_an", an, 8'hF7);
    check("blank_d3_seg", seg, 7'h00);

    // Step edges concurrent with scanning.
    hi0 = step_hi; rise0 = step_rise;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          step_clk = 1'b1;
          repeat (half[i]) @(negedge clk);
          step_clk = 1'b0;
          repeat (half[i]) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 16; j++) begin
          scan_edge();
          k = (4 + j) % 8;
          if (k == 2) begin
            check($sformatf("conc_an%0d", j), an, 8'hFF);
            check($sformatf("conc_seg%0d", j), seg, 7'h7F);
          end else begin
            check($sformatf("conc_an%0d", j), an, exp_an[k]);
            check($sformatf("conc_seg%0d", j), seg, exp_seg[k]);
          end
        end
      end
    join
    check("step_hi_cycles", step_hi - hi0, 5);
    check("step_rises", step_rise - rise0, 5);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_an", an, 8'hFF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    data = 32'h7654_3210; blank = 8'h00; dp_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    scan_edge();
    check("post_rst_an", an, 8'hFE);
    check("post_rst_seg", seg, 7'h40);
    check("post_rst_dp", dp, 1'b1);
    scan_edge();
    check("post_rst_an1", an, 8'hFD);
    check("post_rst_seg1", seg, 7'h79);

    // Four-digit build: wraps after digit 3; main instance stays frozen.
    scan4_edge();
    check("n4_an0", an4, 4'hE);
    check("n4_seg0", seg4, 7'h40);
    scan4_edge();
    check("n4_an1", an4, 4'hD);
    check("n4_seg1", seg4, 7'h79);
    scan4_edge();
    check("n4_an2", an4, 4'hB);
    check("n4_seg2", seg4, 7'h24);
    scan4_edge();
    check("n4_an3", an4, 4'h7);
    check("n4_seg3", seg4, 7'h30);
    scan4_edge();
    check("n4_an_wrap", an4, 4'hE);
    check("n4_seg_wrap", seg4, 7'h40);
    check("freeze_an", an, 8'hFD);
    check("freeze_seg", seg, 7'h79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
